// File: rtl/tag_pool_ctrl.sv
// Command tag pool controller.
// Holds a free-list FIFO of TAG_COUNT tags shared by NUM_CLASSES command
// classes. Grants tags round-robin subject to per-class outstanding limits,
// stores per-tag owner class and metadata at allocation, and returns them
// when a response frees the tag.
module tag_pool_ctrl #(
  parameter int TAG_WIDTH   = 8,
  parameter int TAG_COUNT   = 256,
  parameter int NUM_CLASSES = 4,
  parameter int META_WIDTH  = 64
) (
  input  logic                                 clock,
  input  logic                                 rstn,
  input  logic [NUM_CLASSES*(TAG_WIDTH+1)-1:0] class_limit_in,
  input  logic [NUM_CLASSES-1:0]               alloc_req_in,
  input  logic [NUM_CLASSES*META_WIDTH-1:0]    alloc_meta_in,
  output logic                                 alloc_valid_out,
  output logic [NUM_CLASSES-1:0]               alloc_grant_out,
  output logic [TAG_WIDTH-1:0]                 alloc_tag_out,
  input  logic                                 free_valid_in,
  input  logic [TAG_WIDTH-1:0]                 free_tag_in,
  output logic                                 free_valid_out,
  output logic [$clog2(NUM_CLASSES)-1:0]       free_class_out,
  output logic [META_WIDTH-1:0]                free_meta_out,
  output logic [NUM_CLASSES*(TAG_WIDTH+1)-1:0] outstanding_out,
  output logic [TAG_WIDTH:0]                   free_count_out,
  output logic                                 ready_out,
  output logic [1:0]                           error_out
);

  localparam int CLASS_W = $clog2(NUM_CLASSES);
  localparam int CNT_W   = TAG_WIDTH + 1;
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(TAG_COUNT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    TAG_BUFFER_RESET,
    TAG_BUFFER_INIT,
    TAG_BUFFER_READY
  } state_e;

  // Per-class views of the flat input buses; class i occupies slice i.
  logic [NUM_CLASSES-1:0][CNT_W-1:0]      limit;
  logic [NUM_CLASSES-1:0][META_WIDTH-1:0] meta_in;
  assign limit   = class_limit_in;
  assign meta_in = alloc_meta_in;

  // Control state
  state_e                            state_q, state_d;
  logic [TAG_WIDTH-1:0]              head_q, head_d;
  logic [TAG_WIDTH-1:0]              tail_q, tail_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic [TAG_COUNT-1:0]              in_use_q, in_use_d;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CLASS_W-1:0]                last_q, last_d;

  // Registered outputs
  logic                   alloc_valid_q, alloc_valid_d;
  logic [NUM_CLASSES-1:0] alloc_grant_q, alloc_grant_d;
  logic [TAG_WIDTH-1:0]   alloc_tag_q, alloc_tag_d;
  logic                   free_valid_q, free_valid_d;
  logic [CLASS_W-1:0]     free_class_q, free_class_d;
  logic [META_WIDTH-1:0]  free_meta_q, free_meta_d;
  logic                   ready_q, ready_d;
  logic [1:0]             error_q, error_d;

  // Storage: free-list FIFO and per-tag owner/metadata RAM
  logic [TAG_WIDTH-1:0]  fifo_mem  [TAG_COUNT];
  logic [CLASS_W-1:0]    owner_mem [TAG_COUNT];
  logic [META_WIDTH-1:0] meta_mem  [TAG_COUNT];

  logic                   fifo_we;
  logic [TAG_WIDTH-1:0]   fifo_wdata;
  logic [TAG_WIDTH-1:0]   head_tag;
  logic [CLASS_W-1:0]     free_owner;
  logic                   do_grant;
  logic                   do_free;
  logic [NUM_CLASSES-1:0] eligible;
  logic                   found_hi, found_lo;
  logic [CLASS_W-1:0]     idx_hi, idx_lo, grant_idx;

  assign head_tag   = fifo_mem[head_q];
  assign free_owner = owner_mem[free_tag_in];

  function automatic logic [TAG_WIDTH-1:0] next_ptr(input logic [TAG_WIDTH-1:0] p);
    return (p == LAST_TAG) ? '0 : p + TAG_WIDTH'(1);
  endfunction

  // Round-robin arbiter: lowest eligible class above the last granted one,
  // otherwise wrap to the lowest eligible class at or below it.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      eligible[i] = alloc_req_in[i] && (outstanding_q[i] < limit[i]) && !alloc_grant_q[i];
    end
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (!found_hi && eligible[i] && (i > int'(last_q))) begin
        found_hi = 1'b1;
        idx_hi   = CLASS_W'(i);
      end
    end
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (!found_lo && eligible[i] && (i <= int'(last_q))) begin
        found_lo = 1'b1;
        idx_lo   = CLASS_W'(i);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
    do_grant  = (state_q == TAG_BUFFER_READY) && (found_hi || found_lo) && (count_q != '0);
    do_free   = (state_q == TAG_BUFFER_READY) && free_valid_in &&
                (free_tag_in <= LAST_TAG) && in_use_q[free_tag_in];
  end

  // Next-state logic for the FSM, free list, counters and registered outputs.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    in_use_d      = in_use_q;
    outstanding_d = outstanding_q;
    last_d        = last_q;
    ready_d       = ready_q;
    error_d       = error_q;
    alloc_valid_d = 1'b0;
    alloc_grant_d = '0;
    alloc_tag_d   = '0;
    free_valid_d  = 1'b0;
    free_class_d  = '0;
    free_meta_d   = '0;
    fifo_we       = 1'b0;
    fifo_wdata    = tail_q;

    case (state_q)
      TAG_BUFFER_RESET: state_d = TAG_BUFFER_INIT;

      TAG_BUFFER_INIT: begin
        // Tag n is pushed on the n-th INIT cycle, so the tail doubles as the value.
        fifo_we    = 1'b1;
        fifo_wdata = tail_q;
        tail_d     = next_ptr(tail_q);
        count_d    = count_q + CNT_ONE;
        if (tail_q == LAST_TAG) begin
          state_d = TAG_BUFFER_READY;
          ready_d = 1'b1;
        end
      end

      TAG_BUFFER_READY: begin
        if (do_grant) begin
          alloc_valid_d            = 1'b1;
          alloc_grant_d[grant_idx] = 1'b1;
          alloc_tag_d              = head_tag;
          head_d                   = next_ptr(head_q);
          in_use_d[head_tag]       = 1'b1;
          last_d                   = grant_idx;
        end
        if (do_free) begin
          free_valid_d          = 1'b1;
          free_class_d          = free_owner;
          free_meta_d           = meta_mem[free_tag_in];
          in_use_d[free_tag_in] = 1'b0;
          fifo_we               = 1'b1;
          fifo_wdata            = free_tag_in;
          tail_d                = next_ptr(tail_q);
        end
        if (free_valid_in && !do_free) error_d[0] = 1'b1;
        if (do_grant && !do_free) count_d = count_q - CNT_ONE;
        if (do_free && !do_grant) count_d = count_q + CNT_ONE;
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (do_grant && grant_idx == CLASS_W'(i) && !(do_free && free_owner == CLASS_W'(i)))
            outstanding_d[i] = outstanding_q[i] + CNT_ONE;
          else if (do_free && free_owner == CLASS_W'(i) && !(do_grant && grant_idx == CLASS_W'(i)))
            outstanding_d[i] = outstanding_q[i] - CNT_ONE;
        end
      end

      default: state_d = TAG_BUFFER_RESET;
    endcase

    if (free_valid_in && state_q != TAG_BUFFER_READY) error_d[1] = 1'b1;
  end

  // FSM, pointers, counters, bitmap and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= TAG_BUFFER_RESET;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      in_use_q      <= '0;
      outstanding_q <= '0;
      last_q        <= CLASS_W'(NUM_CLASSES - 1);
      alloc_valid_q <= 1'b0;
      alloc_grant_q <= '0;
      alloc_tag_q   <= '0;
      free_valid_q  <= 1'b0;
      free_class_q  <= '0;
      free_meta_q   <= '0;
      ready_q       <= 1'b0;
      error_q       <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      in_use_q      <= in_use_d;
      outstanding_q <= outstanding_d;
      last_q        <= last_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_grant_q <= alloc_grant_d;
      alloc_tag_q   <= alloc_tag_d;
      free_valid_q  <= free_valid_d;
      free_class_q  <= free_class_d;
      free_meta_q   <= free_meta_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
    end
  end

  // Free-list and tag RAM writes.
  // NOTE: the RAMs have no reset; INIT rewrites every FIFO slot and the in-use bitmap guards the tag RAM.
  always_ff @(posedge clock) begin
    if (fifo_we) fifo_mem[tail_q] <= fifo_wdata;
    if (do_grant) begin
      owner_mem[head_tag] <= grant_idx;
      meta_mem[head_tag]  <= meta_in[grant_idx];
    end
  end

  assign alloc_valid_out = alloc_valid_q;
  assign alloc_grant_out = alloc_grant_q;
  assign alloc_tag_out   = alloc_tag_q;
  assign free_valid_out  = free_valid_q;
  assign free_class_out  = free_class_q;
  assign free_meta_out   = free_meta_q;
  assign outstanding_out = outstanding_q;
  assign free_count_out  = count_q;
  assign ready_out       = ready_q;
  assign error_out       = error_q;

endmodule

// File: tb/tb_tag_pool_ctrl.sv
// Directed bench for tag_pool_ctrl with an 8-tag, 4-class pool.
module tb_tag_pool_ctrl;
  localparam int TW = 3;
  localparam int TC = 8;
  localparam int NC = 4;
  localparam int MW = 32;
  localparam int CW = TW + 1;

  logic               clock = 1'b0;
  logic               rstn  = 1'b1;
  logic [NC*CW-1:0]   limits = '0;
  logic [NC-1:0]      req = '0;
  logic [NC*MW-1:0]   meta = '0;
  logic               alloc_valid;
  logic [NC-1:0]      alloc_grant;
  logic [TW-1:0]      alloc_tag;
  logic               free_valid = 1'b0;
  logic [TW-1:0]      free_tag = '0;
  logic               free_valid_o;
  logic [1:0]         free_class;
  logic [MW-1:0]      free_meta;
  logic [NC*CW-1:0]   outstanding;
  logic [TW:0]        free_count;
  logic               ready;
  logic [1:0]         error;

  int n_cmp = 0;
  int n_err = 0;

  tag_pool_ctrl #(
    .TAG_WIDTH(TW), .TAG_COUNT(TC), .NUM_CLASSES(NC), .META_WIDTH(MW)
  ) dut (
    .clock           (clock),
    .rstn            (rstn),
    .class_limit_in  (limits),
    .alloc_req_in    (req),
    .alloc_meta_in   (meta),
    .alloc_valid_out (alloc_valid),
    .alloc_grant_out (alloc_grant),
    .alloc_tag_out   (alloc_tag),
    .free_valid_in   (free_valid),
    .free_tag_in     (free_tag),
    .free_valid_out  (free_valid_o),
    .free_class_out  (free_class),
    .free_meta_out   (free_meta),
    .outstanding_out (outstanding),
    .free_count_out  (free_count),
    .ready_out       (ready),
    .error_out       (error)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset and run through the full 9-cycle initialisation.
  task automatic reset_pool();
    req        = '0;
    free_valid = 1'b0;
    rstn       = 1'b0;
    #2;
    step();
    rstn = 1'b1;
    repeat (9) step();
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL rst_alloc_valid: got %b want 0", alloc_valid); end
    n_cmp++; if (alloc_grant !== 4'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0", alloc_grant); end
    n_cmp++; if (free_count !== 4'd0) begin n_err++; $display("FAIL rst_free_count: got %0d want 0", free_count); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (error !== 2'b00) begin n_err++; $display("FAIL rst_error: got %b want 00", error); end
    n_cmp++; if (outstanding !== 16'h0) begin n_err++; $display("FAIL rst_outstanding: got %h want 0", outstanding); end
    limits = 16'h8888;
    req    = 4'b0001;
    step();
    rstn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL init_no_grant[%0d]: got %b want 0", k, alloc_valid); end
      if (k < 9) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL init_ready_early[%0d]: got %b want 0", k, ready); end
      end else begin
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL init_ready: got %b want 1", ready); end
        n_cmp++; if (free_count !== 4'd8) begin n_err++; $display("FAIL init_free_count: got %0d want 8", free_count); end
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_g;
    logic [TW-1:0] exp_t;
    limits = 16'h8888;
    reset_pool();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_g = 4'b0001 << (k % 4);
      exp_t = TW'(k);
      n_cmp++; if (alloc_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", k, alloc_valid); end
      n_cmp++; if (alloc_grant !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, alloc_grant, exp_g); end
      n_cmp++; if (alloc_tag !== exp_t) begin n_err++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, alloc_tag, exp_t); end
    end
    step();
    n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty_stall: got %b want 0", alloc_valid); end
    n_cmp++; if (free_count !== 4'd0) begin n_err++; $display("FAIL rr_free_count: got %0d want 0", free_count); end
    n_cmp++; if (outstanding !== 16'h2222) begin n_err++; $display("FAIL rr_outstanding: got %h want 2222", outstanding); end
    req = '0;
  endtask

  task automatic test_limit();
    logic          exp_v;
    logic [TW-1:0] exp_t;
    limits = 16'h8882;
    reset_pool();
    req = 4'b0001;
    for (int j = 0; j < 6; j++) begin
      step();
      exp_v = (j == 0 || j == 2);
      exp_t = (j == 2) ? 3'd1 : 3'd0;
      n_cmp++; if (alloc_valid !== exp_v) begin n_err++; $display("FAIL lim2_valid[%0d]: got %b want %b", j, alloc_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (alloc_tag !== exp_t) begin n_err++; $display("FAIL lim2_tag[%0d]: got %0d want %0d", j, alloc_tag, exp_t); end
      end
    end
    limits = 16'h8888;
    for (int j = 0; j < 12; j++) begin
      step();
      exp_v = (j % 2 == 0);
      exp_t = TW'(2 + j / 2);
      n_cmp++; if (alloc_valid !== exp_v) begin n_err++; $display("FAIL lim8_valid[%0d]: got %b want %b", j, alloc_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (alloc_tag !== exp_t) begin n_err++; $display("FAIL lim8_tag[%0d]: got %0d want %0d", j, alloc_tag, exp_t); end
      end
    end
    repeat (2) step();
    n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL exhaust_stall: got %b want 0", alloc_valid); end
    n_cmp++; if (free_count !== 4'd0) begin n_err++; $display("FAIL exhaust_free_count: got %0d want 0", free_count); end
    n_cmp++; if (outstanding !== 16'h0008) begin n_err++; $display("FAIL exhaust_outstanding: got %h want 0008", outstanding); end
    req = '0;
  endtask

  task automatic test_free_meta();
    logic [TW-1:0] order [5];
    logic          exp_v;
    order[0] = 3'd4; order[1] = 3'd5; order[2] = 3'd6; order[3] = 3'd7; order[4] = 3'd3;
    limits = 16'h8888;
    reset_pool();
    req = 4'b0001;
    repeat (5) step();
    req = 4'b0100;
    meta[2*MW +: MW] = 32'hDEAD_BEEF;
    step();
    n_cmp++; if (alloc_grant !== 4'b0100) begin n_err++; $display("FAIL fm_grant: got %b want 0100", alloc_grant); end
    n_cmp++; if (alloc_tag !== 3'd3) begin n_err++; $display("FAIL fm_tag: got %0d want 3", alloc_tag); end
    req        = '0;
    meta       = '0;
    free_valid = 1'b1;
    free_tag   = 3'd3;
    step();
    free_valid = 1'b0;
    n_cmp++; if (free_valid_o !== 1'b1) begin n_err++; $display("FAIL fm_free_valid: got %b want 1", free_valid_o); end
    n_cmp++; if (free_class !== 2'd2) begin n_err++; $display("FAIL fm_free_class: got %0d want 2", free_class); end
    n_cmp++; if (free_meta !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fm_free_meta: got %h want deadbeef", free_meta); end
    n_cmp++; if (outstanding !== 16'h0003) begin n_err++; $display("FAIL fm_outstanding: got %h want 0003", outstanding); end
    n_cmp++; if (free_count !== 4'd5) begin n_err++; $display("FAIL fm_free_count: got %0d want 5", free_count); end
    req = 4'b0001;
    for (int j = 0; j < 9; j++) begin
      step();
      exp_v = (j % 2 == 0);
      n_cmp++; if (alloc_valid !== exp_v) begin n_err++; $display("FAIL fm_realloc_valid[%0d]: got %b want %b", j, alloc_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (alloc_tag !== order[j/2]) begin n_err++; $display("FAIL fm_realloc_tag[%0d]: got %0d want %0d", j, alloc_tag, order[j/2]); end
      end
    end
    req = '0;
  endtask

  task automatic test_errors();
    req        = '0;
    free_valid = 1'b0;
    rstn       = 1'b0;
    #2;
    step();
    rstn = 1'b1;
    step();
    free_valid = 1'b1;
    free_tag   = 3'd0;
    step();
    free_valid = 1'b0;
    n_cmp++; if (error !== 2'b10) begin n_err++; $display("FAIL err_init_free: got %b want 10", error); end
    repeat (7) step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL err_ready: got %b want 1", ready); end
    n_cmp++; if (free_count !== 4'd8) begin n_err++; $display("FAIL err_init_count: got %0d want 8", free_count); end
    free_valid = 1'b1;
    free_tag   = 3'd5;
    step();
    free_valid = 1'b0;
    n_cmp++; if (error !== 2'b11) begin n_err++; $display("FAIL err_not_in_use: got %b want 11", error); end
    n_cmp++; if (free_valid_o !== 1'b0) begin n_err++; $display("FAIL err_free_valid: got %b want 0", free_valid_o); end
    n_cmp++; if (free_count !== 4'd8) begin n_err++; $display("FAIL err_free_count: got %0d want 8", free_count); end
    n_cmp++; if (outstanding !== 16'h0) begin n_err++; $display("FAIL err_outstanding: got %h want 0", outstanding); end
    repeat (3) step();
    n_cmp++; if (error !== 2'b11) begin n_err++; $display("FAIL err_sticky: got %b want 11", error); end
  endtask

  task automatic test_back_to_back();
    limits = 16'h8888;
    reset_pool();
    req = 4'b0010;
    step();
    n_cmp++; if (alloc_grant !== 4'b0010) begin n_err++; $display("FAIL sim_first_grant: got %b want 0010", alloc_grant); end
    n_cmp++; if (alloc_tag !== 3'd0) begin n_err++; $display("FAIL sim_first_tag: got %0d want 0", alloc_tag); end
    step();
    n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL sim_no_repeat: got %b want 0", alloc_valid); end
    free_valid = 1'b1;
    free_tag   = 3'd0;
    step();
    free_valid = 1'b0;
    req        = '0;
    n_cmp++; if (alloc_valid !== 1'b1) begin n_err++; $display("FAIL sim_alloc_valid: got %b want 1", alloc_valid); end
    n_cmp++; if (alloc_tag !== 3'd1) begin n_err++; $display("FAIL sim_alloc_tag: got %0d want 1", alloc_tag); end
    n_cmp++; if (free_valid_o !== 1'b1) begin n_err++; $display("FAIL sim_free_valid: got %b want 1", free_valid_o); end
    n_cmp++; if (free_class !== 2'd1) begin n_err++; $display("FAIL sim_free_class: got %0d want 1", free_class); end
    n_cmp++; if (outstanding !== 16'h0010) begin n_err++; $display("FAIL sim_outstanding: got %h want 0010", outstanding); end
    n_cmp++; if (free_count !== 4'd7) begin n_err++; $display("FAIL sim_free_count: got %0d want 7", free_count); end
  endtask

  task automatic test_mid_reset();
    req = 4'b1111;
    repeat (2) step();
    rstn = 1'b0;
    #1;
    n_cmp++; if (alloc_valid !== 1'b0 || alloc_grant !== 4'b0 || alloc_tag !== 3'd0)
      begin n_err++; $display("FAIL mid_rst_alloc: got v=%b g=%b t=%0d want all 0", alloc_valid, alloc_grant, alloc_tag); end
    n_cmp++; if (free_valid_o !== 1'b0 || free_class !== 2'd0 || free_meta !== 32'h0)
      begin n_err++; $display("FAIL mid_rst_free: got v=%b c=%0d m=%h want all 0", free_valid_o, free_class, free_meta); end
    n_cmp++; if (outstanding !== 16'h0 || free_count !== 4'd0)
      begin n_err++; $display("FAIL mid_rst_counts: got out=%h cnt=%0d want 0", outstanding, free_count); end
    n_cmp++; if (ready !== 1'b0 || error !== 2'b00)
      begin n_err++; $display("FAIL mid_rst_status: got rdy=%b err=%b want 0", ready, error); end
    step();
    rstn = 1'b1;
    repeat (9) step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reinit_ready: got %b want 1", ready); end
    n_cmp++; if (free_count !== 4'd8) begin n_err++; $display("FAIL reinit_free_count: got %0d want 8", free_count); end
    n_cmp++; if (outstanding !== 16'h0) begin n_err++; $display("FAIL reinit_outstanding: got %h want 0", outstanding); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_limit();
    test_free_meta();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
